// File: rtl/spi_counter_rx.sv
// ---------------------------------------------------------------------------
// spi_counter_rx
//   SPI mode-0 slave receive front-end for the FND display path. The raw
//   SCK/MOSI/SS pins are asynchronous to clk. Each pin is synchronized and
//   edge-detected, and one 16-bit MSB-first frame is assembled per SS-low
//   window. A frame is accepted when it has exactly 16 bits and a 2'b00
//   header. The 14-bit payload is then presented with a one-cycle valid
//   pulse. MISO is not driven.
//
// Ports
//   clk           in   system clock; the only clock in the block
//   reset         in   synchronous, active-high reset
//   sclk          in   raw SPI clock (asynchronous)
//   mosi          in   raw SPI data, sampled on SCK rise (asynchronous)
//   ss            in   raw slave select, active-low (asynchronous)
//   o_counter     out  last accepted 14-bit counter value
//   o_data_valid  out  1-cycle pulse; o_counter changes in the same cycle
//   o_frame_err   out  1-cycle pulse; the frame was rejected
//   o_busy        out  high while a frame is being shifted in
// ---------------------------------------------------------------------------
module spi_counter_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        ss,
  output logic [13:0] o_counter,
  output logic        o_data_valid,
  output logic        o_frame_err,
  output logic        o_busy
);

  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IDLE_W = $clog2(SYNC_STAGES + 3);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_e;

  // Synchronizer chains; the last stage is the synced pin value
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q,   ss_sync_d;
  logic sclk_sync, mosi_sync, ss_sync;

  // One delay flop per pin, and registered edge strobes. mosi_dly_q lines up
  // with sck_rise_q, so the bit seen with a strobe is the one present at the rise.
  logic sclk_dly_q, sclk_dly_d;
  logic mosi_dly_q, mosi_dly_d;
  logic ss_dly_q,   ss_dly_d;
  logic sck_rise_q, sck_rise_d;
  logic ss_rise_q,  ss_rise_d;
  logic ss_fall_q,  ss_fall_d;

  state_e             state_q,   state_d;
  logic [15:0]        shift_q,   shift_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]   tmo_q,     tmo_d;
  logic [IDLE_W-1:0]  idle_q,    idle_d;
  logic [13:0]        counter_q, counter_d;
  logic               valid_q,   valid_d;
  logic               err_q,     err_d;

  // Frame contents after the current cycle's shift (if any), used for eval
  logic [15:0] shift_nxt;
  logic [4:0]  cnt_nxt;

  assign sclk_sync = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_sync = mosi_sync_q[SYNC_STAGES-1];
  assign ss_sync   = ss_sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
    sclk_dly_d  = sclk_sync;
    mosi_dly_d  = mosi_sync;
    ss_dly_d    = ss_sync;
    sck_rise_d  = sclk_sync & ~sclk_dly_q;
    ss_rise_d   = ss_sync & ~ss_dly_q;
    ss_fall_d   = ~ss_sync & ss_dly_q;

    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tmo_d     = tmo_q;
    idle_d    = idle_q;
    counter_d = counter_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    shift_nxt = shift_q;
    cnt_nxt   = bit_cnt_q;

    case (state_q)
      // SS must read high for SYNC_STAGES+2 consecutive cycles before a frame
      // can start. This flushes the reset-time idle level out of the
      // synchronizer, so a frame already running at reset release is ignored.
      WAIT_IDLE: begin
        if (ss_sync) begin
          if (idle_q == IDLE_W'(SYNC_STAGES + 1)) begin
            state_d = IDLE;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end else begin
          idle_d = '0;
        end
      end

      IDLE: begin
        if (ss_fall_q) begin
          shift_d   = '0;
          bit_cnt_d = '0;
          tmo_d     = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (sck_rise_q) begin
          shift_nxt = {shift_q[14:0], mosi_dly_q};
          cnt_nxt   = (bit_cnt_q == 5'd17) ? 5'd17 : bit_cnt_q + 5'd1;
          tmo_d     = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
        shift_d   = shift_nxt;
        bit_cnt_d = cnt_nxt;

        // Timeout takes priority over a coincident SS rise
        if (!sck_rise_q && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          idle_d  = '0;
          state_d = WAIT_IDLE;
        end else if (ss_rise_q) begin
          // Evaluated on the post-shift frame, so a coincident last bit counts
          if (cnt_nxt == 5'd16 && shift_nxt[15:14] == 2'b00) begin
            counter_d = shift_nxt[13:0];
            valid_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end

      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Synchronizers start at the idle pin levels so reset release creates no false edge
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      sclk_dly_q  <= 1'b0;
      mosi_dly_q  <= 1'b0;
      ss_dly_q    <= 1'b1;
      sck_rise_q  <= 1'b0;
      ss_rise_q   <= 1'b0;
      ss_fall_q   <= 1'b0;
      state_q     <= WAIT_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      tmo_q       <= '0;
      idle_q      <= '0;
      counter_q   <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments: all flops update together from pre-edge values.
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_sync_q   <= ss_sync_d;
      sclk_dly_q  <= sclk_dly_d;
      mosi_dly_q  <= mosi_dly_d;
      ss_dly_q    <= ss_dly_d;
      sck_rise_q  <= sck_rise_d;
      ss_rise_q   <= ss_rise_d;
      ss_fall_q   <= ss_fall_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      tmo_q       <= tmo_d;
      idle_q      <= idle_d;
      counter_q   <= counter_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign o_counter    = counter_q;
  assign o_data_valid = valid_q;
  assign o_frame_err  = err_q;
  assign o_busy       = (state_q == SHIFT);

endmodule
